// File: rtl/soc_mem_pkg.sv
// soc_mem_pkg
// Shared constants for the Block_RAM arbitration slice.
//   OWNER_A / OWNER_B : requester tags used for last_owner and read-return routing
//   BRAM_AW / BRAM_DW : default RAM word-address and data widths
//   BURST_CW          : width of the B burst-lock counter
package soc_mem_pkg;

    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    localparam int unsigned BRAM_AW  = 14;
    localparam int unsigned BRAM_DW  = 32;
    localparam int unsigned BURST_CW = 8;

    // The requester that is not 'owner'; used for the round-robin tie break.
    function automatic logic other_owner(input logic owner);
        return ~owner;
    endfunction

endpackage

// File: rtl/bram_arb_grant.sv
// bram_arb_grant
// Picks at most one requester per cycle: round-robin on ties, except that B may hold
// the RAM for up to MAX_BURST consecutive grants while b_lock is set and A is waiting.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   a_req, b_req   : access requests
//   b_lock         : B asks for back-to-back grants
//   a_gnt, b_gnt   : combinational grants (both 0 while rst=1)
module bram_arb_grant
    import soc_mem_pkg::*;
#(
    parameter int unsigned MAX_BURST = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic a_req,
    input  logic b_req,
    input  logic b_lock,
    output logic a_gnt,
    output logic b_gnt
);

    localparam logic [BURST_CW-1:0] BurstMax = BURST_CW'(MAX_BURST);

    logic                last_owner;
    logic [BURST_CW-1:0] burst_cnt;
    logic                pick_b;

    always_comb begin
        pick_b = b_req;
        if (a_req && b_req) begin
            if (last_owner == OWNER_B && b_lock && burst_cnt < BurstMax) begin
                pick_b = 1'b1;
            end else begin
                pick_b = (other_owner(last_owner) == OWNER_B);
            end
        end
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (!rst) begin
            a_gnt = a_req && !pick_b;
            b_gnt = b_req && pick_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner <= OWNER_B;  // so A wins the first tie
            burst_cnt  <= '0;
        end else begin
            if (a_gnt || b_gnt) begin
                last_owner <= b_gnt ? OWNER_B : OWNER_A;
            end
            // Count only locked B grants that actually make A wait; a locked grant
            // with A idle keeps the count, anything else restarts the burst.
            if (b_gnt && b_lock) begin
                if (a_req && burst_cnt < BurstMax) begin
                    burst_cnt <= burst_cnt + 1'b1;
                end
            end else begin
                burst_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter
// Shares one Block_RAM (write port a, read port b, 1-cycle read latency) between the
// CPU-side requester A and the LCD fetch/DMA requester B. One access issues per cycle;
// read data returns to its owner exactly one cycle after the grant.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata        : A request, byte enables (0 = read), address, data
//   a_gnt/a_rvalid/a_rdata           : A grant (comb), read valid, read data
//   b_*                              : same for B, plus b_lock for burst grants
//   ram_waddr/ram_wdata/ram_we       : to Block_RAM addra/dina/wea
//   ram_raddr/ram_rdata              : to Block_RAM addrb, from doutb
module bram_port_arbiter
    import soc_mem_pkg::*;
#(
    parameter int unsigned AW        = BRAM_AW,
    parameter int unsigned DW        = BRAM_DW,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_req,
    input  logic [DW/8-1:0] a_we,
    input  logic [AW-1:0]   a_addr,
    input  logic [DW-1:0]   a_wdata,
    output logic            a_gnt,
    output logic            a_rvalid,
    output logic [DW-1:0]   a_rdata,
    input  logic            b_req,
    input  logic [DW/8-1:0] b_we,
    input  logic [AW-1:0]   b_addr,
    input  logic [DW-1:0]   b_wdata,
    input  logic            b_lock,
    output logic            b_gnt,
    output logic            b_rvalid,
    output logic [DW-1:0]   b_rdata,
    output logic [AW-1:0]   ram_waddr,
    output logic [DW-1:0]   ram_wdata,
    output logic [DW/8-1:0] ram_we,
    output logic [AW-1:0]   ram_raddr,
    input  logic [DW-1:0]   ram_rdata
);

    logic          gnt_any;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          rd_pending;
    logic          rd_owner;

    bram_arb_grant #(
        .MAX_BURST (MAX_BURST)
    ) u_grant (
        .clk    (clk),
        .rst    (rst),
        .a_req  (a_req),
        .b_req  (b_req),
        .b_lock (b_lock),
        .a_gnt  (a_gnt),
        .b_gnt  (b_gnt)
    );

    assign gnt_any = a_gnt | b_gnt;

    // Idle cycles keep the last issued address/data on the RAM pins.
    always_comb begin
        ram_waddr = addr_q;
        ram_wdata = wdata_q;
        ram_we    = '0;
        if (a_gnt) begin
            ram_waddr = a_addr;
            ram_wdata = a_wdata;
            ram_we    = a_we;
        end else if (b_gnt) begin
            ram_waddr = b_addr;
            ram_wdata = b_wdata;
            ram_we    = b_we;
        end
    end

    assign ram_raddr = ram_waddr;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_pending <= 1'b0;
            rd_owner   <= OWNER_A;
        end else begin
            if (gnt_any) begin
                addr_q  <= ram_waddr;
                wdata_q <= ram_wdata;
            end
            rd_pending <= gnt_any && (ram_we == '0);
            rd_owner   <= b_gnt ? OWNER_B : OWNER_A;
        end
    end

    // A reset arriving while a read is in flight drops that return.
    assign a_rvalid = rd_pending && (rd_owner == OWNER_A) && !rst;
    assign b_rvalid = rd_pending && (rd_owner == OWNER_B) && !rst;
    assign a_rdata  = a_rvalid ? ram_rdata : '0;
    assign b_rdata  = b_rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
module tb_bram_port_arbiter;

    localparam int unsigned AW        = 14;
    localparam int unsigned DW        = 32;
    localparam int unsigned BW        = DW / 8;
    localparam int          MAX_BURST = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_req, b_req, b_lock;
    logic [BW-1:0] a_we, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic [AW-1:0] ram_waddr, ram_raddr;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic [BW-1:0] ram_we;

    always #5 clk = ~clk;

    bram_port_arbiter #(
        .AW        (AW),
        .DW        (DW),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_gnt     (a_gnt),
        .a_rvalid  (a_rvalid),
        .a_rdata   (a_rdata),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_lock    (b_lock),
        .b_gnt     (b_gnt),
        .b_rvalid  (b_rvalid),
        .b_rdata   (b_rdata),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata)
    );

    function automatic logic [DW-1:0] byte_mask(input logic [BW-1:0] we);
        return {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
    endfunction

    // Block_RAM stand-in: registered read port, byte-enabled write port.
    logic [DW-1:0] mem [2**AW];
    always @(posedge clk) begin
        ram_rdata <= mem[ram_raddr];
        if (ram_we != '0) begin
            mem[ram_waddr] <= (mem[ram_waddr] & ~byte_mask(ram_we))
                            | (ram_wdata & byte_mask(ram_we));
        end
    end

    // Reference model state
    logic [DW-1:0] ref_mem [2**AW];
    logic          m_last_b;
    int            m_run;
    logic          m_rv_a, m_rv_b;
    logic [DW-1:0] m_rdata;
    logic [AW-1:0] m_addr;
    logic          m_addr_ok;

    logic [1:0]    obs_gnt;
    logic          obs_arv, obs_brv;
    logic [DW-1:0] obs_ard, obs_brd;

    logic [AW-1:0] pool [16];
    logic [1:0]    seq [18];

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: check outputs mid-cycle against the model, advance the model,
    // then return just after the next rising edge so the caller can drive new inputs.
    task automatic cycle();
        logic          ga, gb;
        logic [BW-1:0] we;
        logic [AW-1:0] ad;
        logic [DW-1:0] wd;
        @(negedge clk);
        check_eq("a_rvalid", 64'(a_rvalid), 64'(m_rv_a && !rst));
        check_eq("b_rvalid", 64'(b_rvalid), 64'(m_rv_b && !rst));
        if (m_rv_a && !rst) check_eq("a_rdata", 64'(a_rdata), 64'(m_rdata));
        if (m_rv_b && !rst) check_eq("b_rdata", 64'(b_rdata), 64'(m_rdata));
        obs_gnt = {a_gnt, b_gnt};
        obs_arv = a_rvalid;
        obs_brv = b_rvalid;
        obs_ard = a_rdata;
        obs_brd = b_rdata;

        ga = 1'b0;
        gb = 1'b0;
        if (!rst) begin
            if (a_req && b_req) begin
                if (m_last_b && b_lock && m_run < MAX_BURST) gb = 1'b1;
                else if (m_last_b) ga = 1'b1;
                else gb = 1'b1;
            end else if (a_req) begin
                ga = 1'b1;
            end else if (b_req) begin
                gb = 1'b1;
            end
        end
        check_eq("gnt", 64'({a_gnt, b_gnt}), 64'({ga, gb}));

        we = '0;
        ad = '0;
        wd = '0;
        if (ga) begin
            we = a_we; ad = a_addr; wd = a_wdata;
        end else if (gb) begin
            we = b_we; ad = b_addr; wd = b_wdata;
        end
        if (ga || gb) begin
            check_eq("ram_we", 64'(ram_we), 64'(we));
            check_eq("ram_waddr", 64'(ram_waddr), 64'(ad));
            check_eq("ram_raddr", 64'(ram_raddr), 64'(ad));
            if (we != '0) check_eq("ram_wdata", 64'(ram_wdata), 64'(wd));
        end else begin
            check_eq("ram_we_idle", 64'(ram_we), 64'(0));
            if (m_addr_ok && !rst) check_eq("ram_raddr_hold", 64'(ram_raddr), 64'(m_addr));
        end

        if (rst) begin
            m_last_b  = 1'b1;
            m_run     = 0;
            m_rv_a    = 1'b0;
            m_rv_b    = 1'b0;
            m_addr_ok = 1'b0;
        end else begin
            m_rv_a = ga && (we == '0);
            m_rv_b = gb && (we == '0);
            if (ga || gb) begin
                if (we == '0) m_rdata = ref_mem[ad];
                else ref_mem[ad] = (ref_mem[ad] & ~byte_mask(we)) | (wd & byte_mask(we));
                m_addr    = ad;
                m_addr_ok = 1'b1;
                m_last_b  = gb;
            end
            if (gb && b_lock) begin
                if (a_req && m_run < MAX_BURST) m_run = m_run + 1;
            end else begin
                m_run = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_req = 1'b0; b_req = 1'b0; b_lock = 1'b0;
        a_we = '0; b_we = '0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            if (i == 0) pool[i] = 14'h0000;
            else if (i == 15) pool[i] = 14'h3FFF;
            else pool[i] = 14'(14'h0010 + i - 1);
        end
        m_last_b = 1'b1; m_run = 0; m_rv_a = 1'b0; m_rv_b = 1'b0;
        m_rdata = '0; m_addr = '0; m_addr_ok = 1'b0;
        obs_gnt = '0; obs_arv = 1'b0; obs_brv = 1'b0; obs_ard = '0; obs_brd = '0;
        rst = 1'b1;
        idle_inputs();
        a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
        #1;
        cycle();
        cycle();
        rst = 1'b0;

        // Fill the address pool through A so the model and the RAM agree.
        for (int i = 0; i < 16; i++) begin
            a_req = 1'b1; a_we = 4'hF; a_addr = pool[i];
            a_wdata = (pool[i] == 14'h0010) ? 32'hDEADBEEF : $urandom;
            cycle();
        end
        idle_inputs();
        cycle();

        // Reset, then both requesting without lock: strict alternation from A.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_req = 1'b1; a_we = 4'hF; a_addr = pool[5 + i]; a_wdata = $urandom;
            b_req = 1'b1; b_we = 4'hC; b_addr = pool[10 + i]; b_wdata = $urandom;
            cycle();
            check_eq("t1_alternate", 64'(obs_gnt), (i % 2 == 0) ? 64'(2'b10) : 64'(2'b01));
        end
        idle_inputs();

        // B read of 0x0010 returns on the next cycle, only to B.
        b_req = 1'b1; b_we = '0; b_addr = 14'h0010;
        cycle();
        idle_inputs();
        cycle();
        check_eq("t2_b_rvalid", 64'(obs_brv), 64'(1));
        check_eq("t2_b_rdata", 64'(obs_brd), 64'(32'hDEADBEEF));
        check_eq("t2_a_rvalid", 64'(obs_arv), 64'(0));

        // Burst lock: 16 B grants, then A once, then B again.
        b_req = 1'b1; b_we = 4'hF; b_addr = pool[1]; b_wdata = $urandom;
        cycle();
        for (int i = 0; i < 18; i++) begin
            a_req = 1'b1; a_we = '0; a_addr = pool[2];
            b_req = 1'b1; b_lock = 1'b1; b_we = '0; b_addr = pool[4'($urandom_range(15))];
            cycle();
            seq[i] = obs_gnt;
        end
        idle_inputs();
        for (int i = 0; i < 16; i++) check_eq("t3_burst_b", 64'(seq[i]), 64'(2'b01));
        check_eq("t3_a_after_burst", 64'(seq[16]), 64'(2'b10));
        check_eq("t3_b_again", 64'(seq[17]), 64'(2'b01));
        cycle();

        // Write then immediate read of the top address.
        a_req = 1'b1; a_we = 4'hF; a_addr = 14'h3FFF; a_wdata = 32'h12345678;
        cycle();
        a_we = '0;
        cycle();
        idle_inputs();
        cycle();
        check_eq("t4_a_rvalid", 64'(obs_arv), 64'(1));
        check_eq("t4_a_rdata", 64'(obs_ard), 64'(32'h12345678));

        // Byte-lane write over all-ones.
        a_req = 1'b1; a_we = 4'hF; a_addr = pool[3]; a_wdata = 32'hFFFFFFFF;
        cycle();
        a_we = 4'b0100; a_wdata = 32'h00AB0000;
        cycle();
        a_we = '0;
        cycle();
        idle_inputs();
        cycle();
        check_eq("t5_byte_write", 64'(obs_ard), 64'(32'hFFABFFFF));

        // Reset right after a B read grant drops the return; A wins after reset.
        b_req = 1'b1; b_we = '0; b_addr = pool[2];
        cycle();
        rst = 1'b1; a_req = 1'b1; a_we = '0; a_addr = pool[6];
        cycle();
        check_eq("t6_b_rvalid_rst", 64'(obs_brv), 64'(0));
        check_eq("t6_no_gnt_rst", 64'(obs_gnt), 64'(0));
        cycle();
        rst = 1'b0;
        cycle();
        check_eq("t6_first_gnt_a", 64'(obs_gnt), 64'(2'b10));
        idle_inputs();
        cycle();

        // Random traffic; each requester holds its request until granted.
        for (int n = 0; n < 500; n++) begin
            rst = ($urandom_range(63) == 0);
            b_lock = ($urandom_range(3) != 0);
            if (!a_req && $urandom_range(1) == 1) begin
                a_req = 1'b1;
                a_we = ($urandom_range(1) == 1) ? 4'h0 : 4'($urandom_range(15));
                a_addr = pool[4'($urandom_range(15))];
                a_wdata = $urandom;
            end
            if (!b_req && $urandom_range(3) != 0) begin
                b_req = 1'b1;
                b_we = ($urandom_range(1) == 1) ? 4'h0 : 4'($urandom_range(15));
                b_addr = pool[4'($urandom_range(15))];
                b_wdata = $urandom;
            end
            cycle();
            if (obs_gnt[1]) a_req = 1'b0;
            if (obs_gnt[0]) b_req = 1'b0;
        end
        rst = 1'b0;
        idle_inputs();
        cycle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
